// File: rtl/debounce_oneshot_pkg.sv
// Shared lab constants for the push-button debouncer: FSM encoding and default
// qualification time.
package debounce_oneshot_pkg;

  typedef logic [1:0] db_state_t;

  localparam db_state_t ST_LOW       = 2'b00;
  localparam db_state_t ST_RISE_WAIT = 2'b01;
  localparam db_state_t ST_HIGH      = 2'b10;
  localparam db_state_t ST_FALL_WAIT = 2'b11;

  // 10 ms at 100 MHz
  localparam int DEFAULT_STABLE_CYCLES = 1000000;

  function automatic logic level_is_high(input db_state_t s);
    return (s == ST_HIGH) || (s == ST_FALL_WAIT);
  endfunction

endpackage

// File: rtl/debounce_oneshot_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reused for other
// switch inputs on the board.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/debounce_oneshot.sv
// Push-button debouncer: a level change is accepted only after STABLE_CYCLES+1
// consecutive agreeing synchronized samples; each accepted press emits one pulse.
module debounce_oneshot
  import debounce_oneshot_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_db,
  output logic pulse
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             btn_s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             pulse_q, pulse_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (btn_s) begin
          state_d = ST_RISE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RISE_WAIT: begin
        if (!btn_s) begin
          state_d = ST_LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HIGH;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!btn_s) begin
          state_d = ST_FALL_WAIT;
          cnt_d   = '0;
        end
      end
      ST_FALL_WAIT: begin
        if (btn_s) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next state so they move on the accepting edge.
    btn_db_d = level_is_high(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      btn_db_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_db_q <= btn_db_d;
      pulse_q  <= pulse_d;
    end
  end

  assign btn_db = btn_db_q;
  assign pulse  = pulse_q;

endmodule

// File: tb/tb_debounce_oneshot.sv
// Bench for debounce_oneshot with STABLE_CYCLES=4: directed scenarios with
// literal expectations plus randomized bouncing against a run-length model.
module tb_debounce_oneshot;

  localparam int S = 4;

  logic clk;
  logic reset;
  logic btn_in;
  logic btn_db;
  logic pulse;

  int n_chk;
  int n_fail;

  debounce_oneshot #(.STABLE_CYCLES(S)) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .btn_db (btn_db),
    .pulse  (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the raw level seen two sample edges late must disagree with the
  // accepted level on S+1 consecutive edges before the accepted level flips.
  logic d1, d2;
  logic m_db, m_pulse;
  int   run;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1 = 1'b0; d2 = 1'b0; m_db = 1'b0; m_pulse = 1'b0; run = 0;
    end else begin
      logic seen;
      seen    = d2;
      d2      = d1;
      d1      = btn_in;
      m_pulse = 1'b0;
      if (seen != m_db) run++;
      else run = 0;
      if (run == S + 1) begin
        m_db    = ~m_db;
        run     = 0;
        m_pulse = m_db;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("db_vs_model", btn_db, m_db);
      check("pulse_vs_model", pulse, m_pulse);
    end
  end

  // Up/down counter fed by the strobe, standing in for the downstream counter.
  logic uhdl;
  int   q_cnt;
  always @(posedge clk) begin
    if (pulse) q_cnt = uhdl ? q_cnt + 1 : q_cnt - 1;
  end

  task automatic press_release();
    @(negedge clk) btn_in = 1'b1;
    repeat (12) @(negedge clk);
    btn_in = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int pulses;
    logic db_ok;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    btn_in = 1'b0;
    uhdl   = 1'b1;
    q_cnt  = 0;

    repeat (3) @(negedge clk);
    check("reset_db", btn_db, 1'b0);
    check("reset_pulse", pulse, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Clean press: pulse only after edge 6, btn_db high from edge 6.
    btn_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("press_db_e%0d", k), btn_db, (k >= 6));
      check($sformatf("press_pulse_e%0d", k), pulse, (k == 6));
    end
    // Clean release: btn_db falls on edge 6, no pulse.
    @(negedge clk) btn_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("release_db_e%0d", k), btn_db, (k < 6));
      check($sformatf("release_pulse_e%0d", k), pulse, 1'b0);
    end

    // Bounce: high 2, low 1, then held; one pulse 6 edges after final rise.
    @(negedge clk) btn_in = 1'b1;
    @(negedge clk);
    @(negedge clk) btn_in = 1'b0;
    @(negedge clk) btn_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("bounce_pulse_e%0d", k), pulse, (k == 6));
      check($sformatf("bounce_db_e%0d", k), btn_db, (k >= 6));
    end
    @(negedge clk) btn_in = 1'b0;
    repeat (12) @(negedge clk);

    // Long hold: exactly one pulse over 100 cycles.
    btn_in = 1'b1;
    pulses = 0;
    db_ok  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (pulse) pulses++;
      if (k >= 6 && !btn_db) db_ok = 1'b0;
    end
    check_int("hold_pulse_count", pulses, 1);
    check("hold_db_steady", db_ok, 1'b1);

    // Release glitch from HIGH: low 2 cycles then high again.
    @(negedge clk) btn_in = 1'b0;
    @(negedge clk);
    @(negedge clk) btn_in = 1'b1;
    pulses = 0;
    db_ok  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (pulse) pulses++;
      if (!btn_db) db_ok = 1'b0;
    end
    check_int("glitch_pulse_count", pulses, 0);
    check("glitch_db_steady", db_ok, 1'b1);
    @(negedge clk) btn_in = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in cycle 3 of RISE_WAIT, button held throughout.
    btn_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (pulse) pulses++;
      check($sformatf("rst_db_c%0d", k), btn_db, 1'b0);
    end
    check_int("rst_no_pulse", pulses, 0);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("postrst_pulse_e%0d", k), pulse, (k == 6));
    end
    @(negedge clk) btn_in = 1'b0;
    repeat (12) @(negedge clk);

    // Counter integration.
    q_cnt = 0;
    uhdl  = 1'b1;
    repeat (3) press_release();
    check_int("counter_up3", q_cnt, 3);
    uhdl = 1'b0;
    press_release();
    check_int("counter_down1", q_cnt, 2);

    // Randomized bouncing with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      btn_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 2 * S + 3)) @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        @(negedge clk);
        check("rand_rst_db", btn_db, 1'b0);
        check("rand_rst_pulse", pulse, 1'b0);
        reset = 1'b1;
      end
    end
    btn_in = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_oneshot.md
DEBOUNCE_ONESHOT -- requirements
Module: debounce_oneshot

Interface
REQ-001 Parameter: STABLE_CYCLES, default 1000000, number of consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz); legal range >= 2.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: btn_in  input  1  raw, bouncing, asynchronous push-button level.
REQ-005 Port: btn_db  output  1  debounced level of btn_in, registered.
REQ-006 Port: pulse  output  1  registered single-cycle strobe on each accepted press; feeds the counter's inc_p input.

Function
REQ-007 btn_in SHALL pass through a two-flop synchronizer; the second flop output (btn_s) SHALL be the only version of btn_in seen by the FSM.
REQ-008 The FSM SHALL have four states: LOW, RISE_WAIT, HIGH and FALL_WAIT.
REQ-009 LOW: btn_s=1 -> RISE_WAIT with cnt cleared to 0; otherwise stay in LOW.
REQ-010 RISE_WAIT: btn_s=0 -> LOW (bounce rejected, no pulse); btn_s=1 and cnt=STABLE_CYCLES-1 -> HIGH; otherwise cnt increments by 1.
REQ-011 HIGH: btn_s=0 -> FALL_WAIT with cnt cleared to 0; otherwise stay in HIGH.
REQ-012 FALL_WAIT: btn_s=1 -> HIGH (bounce rejected); btn_s=0 and cnt=STABLE_CYCLES-1 -> LOW; otherwise cnt increments by 1.
REQ-013 cnt width SHALL be clog2(STABLE_CYCLES); cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-014 pulse SHALL be 1 for exactly one cycle, in the cycle after the RISE_WAIT->HIGH transition edge, and 0 at all other times.
REQ-015 pulse SHALL NOT assert on release, on FALL_WAIT->HIGH recovery, or while the button is held.
REQ-016 btn_db SHALL be 1 exactly when the state is HIGH or FALL_WAIT.
REQ-017 Latency: pulse and btn_db SHALL rise on the (STABLE_CYCLES+2)th rising edge after the edge that first samples btn_in high, provided btn_in stays high throughout.
REQ-018 Latency: btn_db SHALL fall on the (STABLE_CYCLES+2)th rising edge after the edge that first samples btn_in low, provided btn_in stays low throughout.
REQ-019 Any glitch shorter than STABLE_CYCLES cycles, as seen at btn_s, SHALL restart qualification from cnt=0 and SHALL NOT change btn_db.
REQ-020 Holding the button continuously SHALL produce exactly one pulse; each further pulse requires a qualified release followed by a qualified press.

Reset
REQ-021 While reset=0, the following SHALL be forced 0 asynchronously: both synchronizer flops, cnt, btn_db and pulse; the FSM SHALL be forced to LOW.
REQ-022 Reset asserted mid-qualification SHALL abort it with no pulse.
REQ-023 If btn_in is high when reset deasserts, the block SHALL treat it as a new press and pulse after the REQ-017 latency.

Structure
REQ-024 The state encoding (LOW=2'b00, RISE_WAIT=2'b01, HIGH=2'b10, FALL_WAIT=2'b11) and the default STABLE_CYCLES SHALL live in the shared lab constants package/include file.
REQ-025 The synchronizer SHALL be a separate sub-module, sync_2ff (clk, reset, d, q), reusable for the UHDL switch input.
REQ-026 The FSM, cnt and output registers SHALL reside in debounce_oneshot; the RTL SHALL contain no combinational path from btn_in to any output.

Verification (STABLE_CYCLES=4)
REQ-027 Clean press: btn_in 0->1 sampled at edge 0 and held -> pulse=1 only in the cycle after edge 6; btn_db=1 from edge 6.
REQ-028 Bounce: btn_in high 2 cycles, low 1 cycle, then held high -> no early pulse; exactly one pulse, 6 edges after the final rise.
REQ-029 Long hold: btn_in held high for 100 cycles -> exactly one pulse; btn_db stays 1 throughout.
REQ-030 Release glitch: from HIGH, btn_in low 2 cycles, then high -> btn_db stays 1; no pulse.
REQ-031 Reset mid-press: reset=0 at cycle 3 of RISE_WAIT, btn_in held high, reset=1 later -> outputs 0 during reset; one pulse STABLE_CYCLES+2 edges after the first post-reset sample.
REQ-032 Integration with the counter: three qualified presses with UHDL=1, starting from Q=0 -> Q=3; then one press with UHDL=0 -> Q=2.
